// File: rtl/frame_scheduler_pkg.sv
// Shared definitions for the vblank game-object update scheduler.
package frame_scheduler_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_GAP, ST_DONE} state_e;

  localparam int N_OBJ_DEF   = 4;
  localparam int TIMEOUT_DEF = 255;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/edge_detect.sv
// Registers a pclk-synchronous level and reports its rising and falling edges.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);
  logic d_q;

  // d_q resets low so a level already high at reset release reads as a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;
  assign fall_o = ~d_i & d_q;
endmodule

// File: rtl/frame_scheduler.sv
// Walks N_OBJ update requesters one at a time during each vertical blanking interval.
// upd_req/upd_ack: request i is held until upd_ack[i] is sampled high or the wait times out.
module frame_scheduler
  import frame_scheduler_pkg::*;
#(
  parameter int N_OBJ   = N_OBJ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             vblnk,
  input  logic             enable,
  input  logic [N_OBJ-1:0] upd_ack,
  output logic [N_OBJ-1:0] upd_req,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic             timeout_err,
  output logic [15:0]      frame_cnt,
  output state_e           state_dbg
);
  localparam int IDX_W = idx_width(N_OBJ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_OBJ - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic rise, fall;

  edge_detect u_vblnk_edge (
    .clk    (pclk),
    .rst_n  (rst_n),
    .d_i    (vblnk),
    .rise_o (rise),
    .fall_o (fall)
  );

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N_OBJ-1:0] upd_req_q;
  logic             busy_q, done_q, overrun_q, timeout_err_q;
  logic [15:0]      frame_cnt_q;

  logic [CNT_W-1:0] cnt_d;
  logic [IDX_W-1:0] idx_d;
  logic [N_OBJ-1:0] req_d;
  logic             ack_hit, expired;

  assign cnt_d   = cnt_q + CNT_W'(1);
  assign idx_d   = idx_q + IDX_W'(1);
  assign req_d   = N_OBJ'(1) << idx_d;
  assign ack_hit = upd_ack[idx_q];
  assign expired = (cnt_d == TIMEOUT_C);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      upd_req_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (rise) frame_cnt_q <= frame_cnt_q + 16'd1;

      case (state_q)
        ST_IDLE: begin
          if (rise && enable) begin
            state_q       <= ST_REQ;
            idx_q         <= '0;
            cnt_q         <= '0;
            upd_req_q     <= N_OBJ'(1);
            busy_q        <= 1'b1;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
          end
        end
        ST_REQ: begin
          // End of blanking wins over a same-edge ack or timeout.
          if (fall) begin
            state_q   <= ST_IDLE;
            upd_req_q <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b1;
          end else if (ack_hit || expired) begin
            upd_req_q <= '0;
            if (!ack_hit) timeout_err_q <= 1'b1;
            if (idx_q == LAST_IDX) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_GAP;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_GAP: begin
          if (fall) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            overrun_q <= 1'b1;
          end else begin
            state_q   <= ST_REQ;
            idx_q     <= idx_d;
            cnt_q     <= '0;
            upd_req_q <= req_d;
          end
        end
        ST_DONE: begin
          if (fall) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign upd_req     = upd_req_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;
  assign frame_cnt   = frame_cnt_q;
  assign state_dbg   = state_q;
endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler: per-cycle {done,busy,upd_req} scoreboard plus flag checks.
module tb_frame_scheduler;
  import frame_scheduler_pkg::*;

  localparam int N_OBJ   = 4;
  localparam int TIMEOUT = 10;
  localparam int ACK_DLY = 3;
  localparam int W       = N_OBJ + 2;

  logic             pclk = 1'b0;
  logic             rst_n = 1'b0;
  logic             vblnk = 1'b0;
  logic             enable = 1'b1;
  logic [N_OBJ-1:0] upd_ack = '0;
  logic [N_OBJ-1:0] upd_req;
  logic             busy, done, overrun, timeout_err;
  logic [15:0]      frame_cnt;
  state_e           state_dbg;

  logic [W-1:0]     exp_q[$];
  logic [N_OBJ-1:0] ack_en = '1;
  int               age[N_OBJ];
  int               tests_run = 0;
  int               fail_cnt = 0;

  frame_scheduler #(.N_OBJ(N_OBJ), .TIMEOUT(TIMEOUT)) dut (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .vblnk       (vblnk),
    .enable      (enable),
    .upd_ack     (upd_ack),
    .upd_req     (upd_req),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun),
    .timeout_err (timeout_err),
    .frame_cnt   (frame_cnt),
    .state_dbg   (state_dbg)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One negedge; the requester model answers a held request on its third sampled cycle.
  task automatic cycle();
    @(negedge pclk);
    for (int i = 0; i < N_OBJ; i++) begin
      if (upd_req[i]) begin
        age[i]++;
        if (age[i] >= ACK_DLY && ack_en[i]) upd_ack[i] = 1'b1;
      end else begin
        age[i]     = 0;
        upd_ack[i] = 1'b0;
      end
    end
  endtask

  task automatic push_trace(input logic [N_OBJ-1:0] mask);
    logic [N_OBJ-1:0] r;
    ack_en = mask;
    exp_q.delete();
    for (int i = 0; i < N_OBJ; i++) begin
      r = '0;
      r[i] = 1'b1;
      repeat (mask[i] ? ACK_DLY : TIMEOUT) exp_q.push_back({1'b0, 1'b1, r});
      if (i < N_OBJ - 1) exp_q.push_back({1'b0, 1'b1, {N_OBJ{1'b0}}});
      else               exp_q.push_back({1'b1, 1'b0, {N_OBJ{1'b0}}});
    end
    exp_q.push_back('0);
  endtask

  task automatic start_round(input logic [N_OBJ-1:0] mask);
    cycle();
    vblnk = 1'b1;
    push_trace(mask);
  endtask

  task automatic expect_cycles(input int n);
    logic [W-1:0] e;
    for (int k = 0; k < n; k++) begin
      if (exp_q.size() == 0) break;
      cycle();
      e = exp_q.pop_front();
      check("trace", {done, busy, upd_req}, e);
    end
  endtask

  task automatic end_frame();
    vblnk = 1'b0;
    cycle();
  endtask

  initial begin
    for (int i = 0; i < N_OBJ; i++) age[i] = 0;

    // Reset state
    #12;
    check("rst_upd_req", upd_req, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {done, overrun, timeout_err}, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_state", state_dbg, ST_IDLE);
    @(negedge pclk);
    rst_n = 1'b1;
    repeat (2) cycle();

    // Normal round, every requester answers
    start_round('1);
    expect_cycles(100);
    check("norm_overrun", overrun, 0);
    check("norm_timeout", timeout_err, 0);
    check("norm_frame_cnt", frame_cnt, 1);
    repeat (3) cycle();
    check("norm_hold_done", {done, busy}, 0);
    check("norm_hold_state", state_dbg, ST_DONE);
    end_frame();
    check("norm_idle", state_dbg, ST_IDLE);

    // Requester 2 never answers
    start_round(4'b1011);
    expect_cycles(100);
    check("tmo_err", timeout_err, 1);
    check("tmo_frame_cnt", frame_cnt, 2);
    end_frame();
    check("tmo_err_sticky", timeout_err, 1);

    // Blanking ends while request 2 is pending
    start_round('1);
    expect_cycles(2 * (ACK_DLY + 1) + 1);
    check("ovr_pre_req", upd_req, 4'b0100);
    check("ovr_tmo_cleared", timeout_err, 0);
    vblnk = 1'b0;
    exp_q.delete();
    cycle();
    check("ovr_upd_req", {done, busy, upd_req}, 0);
    check("ovr_flag", overrun, 1);
    check("ovr_state", state_dbg, ST_IDLE);
    repeat (2) cycle();
    check("ovr_no_done", done, 0);

    // Next round clears overrun; enable dropped mid-round must not abort it
    start_round('1);
    expect_cycles(1);
    check("rec_overrun_clr", overrun, 0);
    enable = 1'b0;
    expect_cycles(100);
    check("rec_frame_cnt", frame_cnt, 4);
    end_frame();

    // Disabled across three frames
    for (int f = 0; f < 3; f++) begin
      cycle();
      vblnk = 1'b1;
      repeat (4) cycle();
      check("dis_quiet", {busy, upd_req}, 0);
      end_frame();
    end
    check("dis_frame_cnt", frame_cnt, 7);

    // Asynchronous reset mid-round, released with vblnk high
    enable = 1'b1;
    start_round('1);
    expect_cycles(ACK_DLY + 2);
    check("arst_pre_req", upd_req, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_upd_req", upd_req, 0);
    check("arst_flags", {done, busy, overrun, timeout_err}, 0);
    check("arst_frame_cnt", frame_cnt, 0);
    check("arst_state", state_dbg, ST_IDLE);
    upd_ack = '0;
    for (int i = 0; i < N_OBJ; i++) age[i] = 0;
    @(negedge pclk);
    rst_n = 1'b1;
    push_trace('1);
    expect_cycles(100);
    check("arst_resume_cnt", frame_cnt, 1);
    end_frame();

    // Frame counter wrap
    enable = 1'b0;
    cycle();
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    check("wrap_pre", frame_cnt, 16'hFFFF);
    cycle();
    vblnk = 1'b1;
    cycle();
    check("wrap_post", frame_cnt, 16'h0000);
    end_frame();

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end
endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 Parameter N_OBJ, default 4: number of game-object update requesters (range 1..16).
REQ-002 Parameter TIMEOUT, default 255: maximum pclk cycles to wait for one requester's ack (range 1..65535).
REQ-003 pclk  input  1  pixel clock (40 MHz, 1056x628 SVGA frame); sole clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 vblnk  input  1  vertical blanking from the timing generator, synchronous to pclk.
REQ-006 enable  input  1  when low, no update round starts.
REQ-007 upd_ack  input  N_OBJ  per-requester acknowledge; bit i completes request i.
REQ-008 upd_req  output  N_OBJ  one-hot or zero update request, registered.
REQ-009 busy  output  1  high while a round is in progress (states REQ/GAP).
REQ-010 done  output  1  one-cycle pulse when a round finishes with all requesters serviced.
REQ-011 overrun  output  1  sticky flag: a round was cut short by the end of vblnk; cleared at the next round start.
REQ-012 timeout_err  output  1  sticky flag: at least one requester timed out in the current or last round; cleared at round start.
REQ-013 frame_cnt  output  16  count of vblnk rising edges, wrapping.

Function
REQ-014 vblnk SHALL be registered into vblnk_q; rise = vblnk & ~vblnk_q; fall = ~vblnk & vblnk_q.
REQ-015 frame_cnt SHALL increment by 1 on every rise, regardless of enable, wrapping 0xFFFF->0x0000.
REQ-016 FSM states: IDLE, REQ, GAP, DONE.
REQ-017 IDLE: on rise with enable=1, go to REQ with idx=0, upd_req=1<<0, clear overrun and timeout_err, zero wait counter; else stay.
REQ-018 REQ: upd_req[idx] held high; wait counter increments each cycle.
REQ-019 REQ: upd_ack[idx] sampled high -> upd_req cleared that edge; if idx==N_OBJ-1 go to DONE with done=1 for one cycle, else go to GAP.
REQ-020 REQ: wait counter reaches TIMEOUT without ack -> set timeout_err, drop request, advance exactly as for an ack (done still pulses on last index).
REQ-021 GAP: exactly one cycle with upd_req=0; then idx+1, upd_req=1<<idx, counter zeroed, go to REQ.
REQ-022 Ack bits other than upd_ack[idx], and any ack outside REQ, SHALL be ignored.
REQ-023 fall while in REQ or GAP: upd_req cleared same edge, overrun set, no done pulse, go to IDLE; fall has priority over ack/timeout on the same edge.
REQ-024 DONE: stay until fall, then IDLE; a rise cannot occur in DONE, so no new round starts until vblnk next rises.
REQ-025 enable deasserted mid-round SHALL NOT abort the round; it only gates round start.
REQ-026 Latency: upd_req[0] high on the first edge where rise is detected (one cycle after vblnk first sampled high).

Reset
REQ-027 rst_n low SHALL asynchronously force: state IDLE, idx 0, upd_req 0, busy 0, done 0, overrun 0, timeout_err 0, frame_cnt 0, vblnk_q 0, wait counter 0.
REQ-028 Reset released with vblnk already high SHALL count as a rise on the first edge (vblnk_q resets to 0).

Structure
REQ-029 State encoding (IDLE/REQ/GAP/DONE) and default N_OBJ/TIMEOUT constants SHALL live in the shared game package.
REQ-030 Edge detection SHALL be a sub-module edge_detect (input, rise, fall outputs); FSM, index and counters stay in frame_scheduler.
REQ-031 idx width = clog2(N_OBJ) (min 1); wait counter width = clog2(TIMEOUT+1).

Verification
REQ-032 N_OBJ=4, enable=1, each ack returned 3 cycles after its req -> req sequence 0001,0000,0010,0000,0100,0000,1000; done pulse once; overrun=0; frame_cnt+1.
REQ-033 TIMEOUT=10, requester 2 never acks -> upd_req[2] high exactly 10 cycles, timeout_err=1, requester 3 still served, done pulses.
REQ-034 vblnk falls while upd_req=0100 -> upd_req=0000 same edge, overrun=1, no done, state IDLE; next rise clears overrun.
REQ-035 enable=0 across 3 frames -> upd_req stays 0, frame_cnt advances by 3.
REQ-036 rst_n pulsed low mid-round (upd_req=0010) -> all outputs zero immediately without a pclk edge; resume on next rise from idx 0.
REQ-037 frame_cnt preloaded near wrap via 65536 rises (or forced) -> 0xFFFF wraps to 0x0000.
